// File: rtl/fp32_mul_pkg.sv
// Shared types and constants for the fp32 multiplier result path.
package fp32_mul_pkg;

    localparam int unsigned FP32_WIDTH = 32;
    localparam int unsigned FLAGS_W    = 3;
    localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic invalid;
        logic underflow;
        logic overflow;
    } mul_flags_t;

    typedef struct packed {
        logic [FP32_WIDTH-1:0] data;
        mul_flags_t            flags;
    } mul_result_t;

endpackage

// File: rtl/fp32_mul_result_buffer_if.sv
// Multiplier-result capture bus and the valid/ready result stream.
interface fp32_mul_result_buffer_if #(
    parameter int unsigned WIDTH = fp32_mul_pkg::FP32_WIDTH
);

    logic                                done_i;
    logic [WIDTH-1:0]                    result_i;
    logic                                overflow_i;
    logic                                underflow_i;
    logic                                invalid_i;
    logic                                m_valid_o;
    logic [WIDTH-1:0]                    m_data_o;
    logic [fp32_mul_pkg::FLAGS_W-1:0]    m_flags_o;
    logic                                m_ready_i;

    modport master (
        output done_i, result_i, overflow_i, underflow_i, invalid_i, m_ready_i,
        input  m_valid_o, m_data_o, m_flags_o
    );

    modport slave (
        input  done_i, result_i, overflow_i, underflow_i, invalid_i, m_ready_i,
        output m_valid_o, m_data_o, m_flags_o
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head; accepts push while full if a pop happens.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, wptr_q, rptr_d, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] head_d;

    // Next pointers/count and the value the head register must show after this edge
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        pop_ok  = pop_i && (count_q != '0);
        push_ok = push_i && (!full_c || pop_ok);
        rptr_d  = pop_ok  ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        // The incoming word becomes the head when it lands in the slot the head moves to
        head_d  = (push_ok && (wptr_q == rptr_d)) ? wdata_i : mem_q[rptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Head data holds its last value once the FIFO drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            valid_o <= (count_d != '0);
            if (count_d != '0) begin
                rdata_o <= head_d;
            end
        end
    end

endmodule

// File: rtl/fp32_mul_result_buffer.sv
// Buffers fp32 multiplier results, re-presents them on a stream, and tracks issue credits.
module fp32_mul_result_buffer
    import fp32_mul_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = FP32_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_i,
    output logic               can_issue_o,
    input  logic               clr_flags_i,
    output logic [FLAGS_W-1:0] sticky_flags_o,
    output logic               err_o,
    fp32_mul_result_buffer_if.slave bus
);

    localparam int unsigned ENTRY_W = WIDTH + FLAGS_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic               pop, push_ok, issue_ok, fifo_full_c, fifo_valid;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    mul_flags_t         in_flags, sticky_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               can_issue_d, err_d;

    always_comb begin
        in_flags      = '{invalid: bus.invalid_i, underflow: bus.underflow_i, overflow: bus.overflow_i};
        fifo_wdata    = {bus.result_i, in_flags};
        pop           = bus.m_valid_o && bus.m_ready_i;
        push_ok       = bus.done_i && (!fifo_full_c || pop);
        issue_ok      = issue_i && can_issue_o;

        // Issue and pop together cancel; a pop never takes the count below zero
        outstanding_d = outstanding_q;
        if (issue_ok && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (pop && !issue_ok && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        can_issue_d = (outstanding_d < CNT_W'(DEPTH));

        // Same-cycle set beats clear for both sticky flags and the error bit
        sticky_d = clr_flags_i ? '0 : mul_flags_t'(sticky_flags_o);
        if (push_ok) begin
            sticky_d = sticky_d | in_flags;
        end
        err_d = err_o && !clr_flags_i;
        if ((bus.done_i && !push_ok) || (issue_i && !can_issue_o)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q  <= '0;
            can_issue_o    <= 1'b1;
            sticky_flags_o <= '0;
            err_o          <= 1'b0;
        end else begin
            outstanding_q  <= outstanding_d;
            can_issue_o    <= can_issue_d;
            sticky_flags_o <= sticky_d;
            err_o          <= err_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.done_i),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .full_c  (fifo_full_c)
    );

    assign bus.m_valid_o = fifo_valid;
    assign bus.m_data_o  = fifo_rdata[ENTRY_W-1:FLAGS_W];
    assign bus.m_flags_o = fifo_rdata[FLAGS_W-1:0];

endmodule

// File: tb/tb_fp32_mul_result_buffer.sv
// Randomized and directed bench for fp32_mul_result_buffer against a queue-based reference model.
module tb_fp32_mul_result_buffer;
    import fp32_mul_pkg::*;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       issue_i;
    logic       can_issue_o;
    logic       clr_flags_i;
    logic [2:0] sticky_flags_o;
    logic       err_o;

    fp32_mul_result_buffer_if #(.WIDTH(FP32_WIDTH)) bus ();

    fp32_mul_result_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (FP32_WIDTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_i        (issue_i),
        .can_issue_o    (can_issue_o),
        .clr_flags_i    (clr_flags_i),
        .sticky_flags_o (sticky_flags_o),
        .err_o          (err_o),
        .bus            (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: buffered results in order, last shown head, credits, sticky bits
    mul_result_t q[$];
    mul_result_t held;
    int          outstanding;
    logic        exp_can;
    logic [2:0]  exp_sticky;
    logic        exp_err;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic iss, input logic dn, input logic [31:0] res,
                         input logic [2:0] fl, input logic rdy, input logic clr, input logic rs);
        logic pop, acc, bad;
        if (rs) begin
            q.delete();
            held        = '0;
            outstanding = 0;
            exp_can     = 1'b1;
            exp_sticky  = 3'b000;
            exp_err     = 1'b0;
        end else begin
            pop = (q.size() != 0) && rdy;
            acc = dn && ((q.size() < DEPTH) || pop);
            bad = (dn && !acc) || (iss && !exp_can);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{data: res, flags: mul_flags_t'(fl)});
            if (iss && exp_can && !pop) outstanding++;
            else if (pop && !(iss && exp_can) && outstanding > 0) outstanding--;
            exp_can    = (outstanding < DEPTH);
            exp_sticky = (clr ? 3'b000 : exp_sticky) | (acc ? fl : 3'b000);
            exp_err    = (clr ? 1'b0 : exp_err) | bad;
            if (q.size() != 0) held = q[0];
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every output
    task automatic cycle(input logic iss, input logic dn, input logic [31:0] res,
                         input logic [2:0] fl, input logic rdy, input logic clr, input logic rs);
        issue_i         = iss;
        bus.done_i      = dn;
        bus.result_i    = res;
        bus.invalid_i   = fl[2];
        bus.underflow_i = fl[1];
        bus.overflow_i  = fl[0];
        bus.m_ready_i   = rdy;
        clr_flags_i     = clr;
        rst_i           = rs;
        @(posedge clk_i);
        #1;
        model(iss, dn, res, fl, rdy, clr, rs);
        check("m_valid", 64'(bus.m_valid_o), 64'(q.size() != 0));
        check("m_data", 64'(bus.m_data_o), 64'(held.data));
        check("m_flags", 64'(bus.m_flags_o), 64'(held.flags));
        check("can_issue", 64'(can_issue_o), 64'(exp_can));
        check("sticky", 64'(sticky_flags_o), 64'(exp_sticky));
        check("err", 64'(err_o), 64'(exp_err));
    endtask

    initial begin
        logic       r_iss, r_dn, r_rdy, r_clr, r_rs;
        logic [2:0] r_fl;

        // Reset values
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("rst_can_issue", 64'(can_issue_o), 64'd1);
        check("rst_m_valid", 64'(bus.m_valid_o), 64'd0);
        check("rst_m_data", 64'(bus.m_data_o), 64'd0);
        check("rst_sticky", 64'(sticky_flags_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);

        // In-order delivery with the consumer always ready
        cycle(0, 1, 32'h3F80_0000, 3'b000, 1, 0, 0);
        check("ord_first_valid", 64'(bus.m_valid_o), 64'd1);
        check("ord_first_data", 64'(bus.m_data_o), 64'h3F80_0000);
        cycle(0, 1, 32'h4000_0000, 3'b000, 1, 0, 0);
        check("ord_second_data", 64'(bus.m_data_o), 64'h4000_0000);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("ord_drained", 64'(bus.m_valid_o), 64'd0);
        check("ord_sticky", 64'(sticky_flags_o), 64'd0);

        // Credits run out after DEPTH issues; one more issue is an error
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            if (i == DEPTH - 2) check("credit_still_high", 64'(can_issue_o), 64'd1);
        end
        check("credit_low", 64'(can_issue_o), 64'd0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("credit_overissue_err", 64'(err_o), 64'd1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 32'h3F80_0000 + 32'(i), 3'b000, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("credit_back", 64'(can_issue_o), 64'd1);
        cycle(0, 0, 0, 0, 1, 1, 0);
        check("err_cleared", 64'(err_o), 64'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0);

        // Sticky flags accumulate; a new flag beats a same-cycle clear
        cycle(0, 1, 32'h7F80_0000, 3'b001, 1, 0, 0);
        cycle(0, 1, FP32_QNAN, 3'b100, 1, 0, 0);
        check("sticky_ovf_inv", 64'(sticky_flags_o), 64'b101);
        cycle(0, 1, 32'h0000_0001, 3'b010, 1, 1, 0);
        check("sticky_clr_vs_unf", 64'(sticky_flags_o), 64'b010);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Full FIFO: a push without pop drops, a push with pop is accepted
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 32'h0000_00A0 + 32'(i), 3'b000, 0, 0, 0);
        check("full_no_err", 64'(err_o), 64'd0);
        cycle(0, 1, 32'h0000_DEAD, 3'b000, 0, 0, 0);
        check("drop_err", 64'(err_o), 64'd1);
        check("drop_head", 64'(bus.m_data_o), 64'h0000_00A0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 32'h0000_BEEF, 3'b000, 1, 0, 0);
        check("full_pop_push_err", 64'(err_o), 64'd0);
        check("full_pop_push_head", 64'(bus.m_data_o), 64'h0000_00A1);

        // Reset with three entries buffered, then a fresh push
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("midrst_m_valid", 64'(bus.m_valid_o), 64'd0);
        check("midrst_can_issue", 64'(can_issue_o), 64'd1);
        check("midrst_m_data", 64'(bus.m_data_o), 64'd0);
        cycle(0, 1, 32'h3F80_0000, 3'b001, 0, 0, 0);
        check("postrst_valid", 64'(bus.m_valid_o), 64'd1);
        check("postrst_data", 64'(bus.m_data_o), 64'h3F80_0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_iss = ($urandom_range(0, 9) < 4);
            r_dn  = ($urandom_range(0, 1) == 1);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_clr = ($urandom_range(0, 15) == 0);
            r_rs  = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            cycle(r_iss, r_dn, $urandom, r_fl, r_rdy, r_clr, r_rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp32_mul_result_buffer.md
# fp32_mul_result_buffer

Downstream companion to the fp32 multiplier. It captures every `done` pulse (result plus overflow/underflow/invalid flags) into a small FIFO and re-presents results on a valid/ready stream. It also runs a credit counter that tells the issuing logic when another multiply may be started without risk of losing a result. The multiplier has no backpressure, so this block is the only place where results can be held.

## Interface

- `DEPTH`, default 4: FIFO entries and maximum outstanding multiplies; power of two, ≥2.
- `WIDTH`, default 32: result width; fixed at 32 for fp32.

- `clk_i`, in, 1: sole clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `issue_i`, in, 1: pulse in the same cycle the multiplier's `valid_i` is asserted. Consumes one credit.
- `can_issue_o`, out, 1: a credit is available. Registered.
- `done_i`, in, 1: multiplier `done_o`.
- `result_i`, in, WIDTH: multiplier `result_o`.
- `overflow_i`, in, 1: multiplier overflow flag.
- `underflow_i`, in, 1: multiplier underflow flag.
- `invalid_i`, in, 1: multiplier invalid flag.
- `m_valid_o`, out, 1: head entry valid.
- `m_data_o`, out, WIDTH: head result.
- `m_flags_o`, out, 3: head flags as {invalid, underflow, overflow}.
- `m_ready_i`, in, 1: consumer accepts the head entry.
- `sticky_flags_o`, out, 3: OR of the flags of all accepted results since the last clear.
- `clr_flags_i`, in, 1: clears `sticky_flags_o` and `err_o`.
- `err_o`, out, 1: sticky protocol error (result dropped or issue without credit).

## Operation

**Push.** On `done_i`, the entry {result, flags} is written when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle. Otherwise the entry is dropped and `err_o` is set.

**Pop.** A pop occurs when `m_valid_o && m_ready_i`. The FIFO is first-word-fall-through: `m_data_o` and `m_flags_o` are the head entry while `m_valid_o` is high. When `m_valid_o` is low, they hold their last value.

**Credit counter.**
- `outstanding` is `$clog2(DEPTH+1)` bits wide. It counts issued results that have not yet been popped.
- Increments on an accepted issue and decrements on a pop. Simultaneous issue and pop leave it unchanged.
- An issue is accepted only when `can_issue_o` is high. `issue_i` while `can_issue_o` is low does not change the counter and sets `err_o`.
- `can_issue_o = (outstanding_next < DEPTH)`, registered.

**Sticky flags.**
- On each accepted push, `sticky_flags_o |=` the incoming flags.
- `clr_flags_i` clears `sticky_flags_o` and `err_o`.
- If a clear and a push with set flags happen in the same cycle, the new flags win (the bits end up set).
- If a clear and a new error happen in the same cycle, `err_o` ends up set.

**Reset.**
- Read pointer, write pointer, count and `outstanding` go to 0.
- `m_valid_o` = 0, `m_data_o` = 0, `m_flags_o` = 0.
- `sticky_flags_o` = 0, `err_o` = 0, `can_issue_o` = 1.
- Reset asserted mid-operation discards all buffered and in-flight accounting. Results that arrive after reset are pushed normally.

**Arithmetic.** Pointers are `$clog2(DEPTH)` bits and wrap naturally at `DEPTH`. The count saturates logically at `DEPTH` and never wraps.

## Timing

- Push to visible: `done_i` in cycle N with the FIFO empty gives `m_valid_o = 1` in cycle N+1. There is no combinational path from `done_i` to any output.
- Pop: the handshake at edge N advances the head, so the next entry (if any) is visible after that edge.
- Credits: `can_issue_o` updates one cycle after the issue or pop that changes it.
  - `DEPTH` back-to-back issues with no pops drive `can_issue_o` low in the cycle after the DEPTH-th issue.
  - A pop in the cycle where `outstanding == DEPTH` raises `can_issue_o` in the next cycle.
- Full plus pop plus push in the same cycle: both are performed, the count is unchanged and no error is raised.
- Empty plus push, with `m_ready_i` held high: the entry is popped in cycle N+1, giving a minimum residence of one cycle.

## Structure

- Package `fp32_mul_pkg`:
  - `mul_flags_t`, a packed struct {invalid, underflow, overflow}.
  - `mul_result_t`, a packed struct {data[31:0], flags}.
  - Constants `FP32_WIDTH = 32`, `FP32_QNAN = 32'h7FC00000`.
- One sub-module, `sync_fifo`, parameterised by width and depth:
  - Flop array, FWFT head, push/pop with simultaneous full-pop-push support.
- The top level adds the credit counter, sticky flags and error logic.

## Test plan

- Reset, then check every output against its reset value: `can_issue_o = 1`, `m_valid_o = 0`, `sticky_flags_o = 3'b000`, `err_o = 0`.
- Push `3F800000` and `40000000` with flags 0, hold `m_ready_i` = 1. Results appear in order at N+1 and N+2, and `sticky_flags_o` stays 0.
- Four issues with `m_ready_i` = 0:
  - `can_issue_o` falls after the 4th issue, and a 5th issue sets `err_o`.
  - One pop raises `can_issue_o` in the next cycle.
- Push `7F800000` with overflow set, then `7FC00000` with invalid set. `sticky_flags_o = 3'b101`. Asserting `clr_flags_i` in the same cycle as an underflow push gives `3'b010`.
- Fill the FIFO (DEPTH = 4), then `done_i` with no pop: the entry is dropped and `err_o` = 1. Repeating with a simultaneous pop: accepted, count unchanged, no error.
- Assert reset with 3 entries buffered: outputs return to reset values, and a subsequent push appears at N+1.
